// File: rtl/lasernet_pkg.sv
// lasernet_pkg: shared constants and the assembler state encoding for the
// LaserNet receive path.
//   PACKET_BYTES / PACKET_WORDS / PACKET_WIDTH : frame geometry (36 bytes, 288 bits)
//   DEFAULT_SYNC_BYTE                          : start-of-frame marker
//   asm_state_e                                : packet_assembler FSM states
package lasernet_pkg;

  localparam int         PACKET_BYTES      = 36;
  localparam int         PACKET_WORDS      = 9;
  localparam int         PACKET_WIDTH      = 288;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h7E;
  localparam logic [5:0] LAST_BYTE_IDX     = 6'(PACKET_BYTES - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;

endpackage

// File: rtl/byte_watchdog.sv
// byte_watchdog: counts idle cycles while enabled and flags expiry on the
// cycle that would be the limit-th consecutive idle cycle.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   clear   : restart the idle count (a byte arrived, or not collecting)
//   enable  : count while high
//   expired : high during the limit-th idle cycle
//   limit   : parameter, idle cycles allowed (must be >= 1)
module byte_watchdog #(
  parameter int unsigned limit = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(limit + 1);

  logic [CW-1:0] count_r;

  // Expiry looks at the count before this cycle's increment, so the abort
  // lands on the edge that completes the limit-th idle cycle.
  assign expired = enable && (count_r == CW'(limit - 1));

  // Idle-cycle counter; saturates at limit so it can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != CW'(limit))) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/packet_assembler.sv
// packet_assembler: hunts for SYNC_BYTE, then collects the next 36 bytes
// MSB-first into a shadow register and publishes them on packet with a
// one-cycle ready pulse.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   byte_in    : received byte
//   byte_valid : byte_in valid strobe
//   packet     : last completed frame, first byte at [287:280]
//   ready      : one-cycle pulse when packet is updated
//   busy       : high while collecting a frame
//   drop_count : saturating count of aborted frames
// Build option: define PKT_TIMEOUT_EN to add the inter-byte watchdog
// (TIMEOUT_CYCLES idle cycles abort the frame). Without it COLLECT waits
// forever and drop_count is tied to zero.
module packet_assembler
  import lasernet_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic [PACKET_WIDTH-1:0] packet,
  output logic                    ready,
  output logic                    busy,
  output logic [7:0]              drop_count
);

  asm_state_e              state_r, state_s;
  logic [5:0]              cnt_r, cnt_s;
  logic [PACKET_WIDTH-1:0] shadow_r, shadow_s;
  logic [PACKET_WIDTH-1:0] packet_r, packet_s;
  logic                    ready_r, ready_s;
  logic                    abort_s;
  logic                    expired_s;

`ifdef PKT_TIMEOUT_EN
  logic [7:0] drop_r;

  byte_watchdog #(
    .limit (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (byte_valid || (state_r != ST_COLLECT)),
    .enable  (state_r == ST_COLLECT),
    .expired (expired_s)
  );

  // Aborted-frame counter, saturating at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_r <= 8'd0;
    end else if (abort_s && (drop_r != 8'hFF)) begin
      drop_r <= drop_r + 8'd1;
    end else begin
      drop_r <= drop_r;
    end
  end

  assign drop_count = drop_r;
`else
  logic [32:0] unused_cfg_s;

  assign expired_s    = 1'b0;
  assign drop_count   = 8'd0;
  assign unused_cfg_s = {TIMEOUT_CYCLES, abort_s};
`endif

  // Next-state, shift and publish decisions.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    shadow_s = shadow_r;
    packet_s = packet_r;
    ready_s  = 1'b0;
    abort_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          state_s  = ST_COLLECT;
          cnt_s    = 6'd0;
          shadow_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        // A byte arriving on the expiry cycle wins over the watchdog.
        if (byte_valid) begin
          shadow_s = {shadow_r[PACKET_WIDTH-9:0], byte_in};
          if (cnt_r == LAST_BYTE_IDX) begin
            packet_s = shadow_s;
            ready_s  = 1'b1;
            state_s  = ST_IDLE;
            cnt_s    = 6'd0;
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end else if (expired_s) begin
          state_s  = ST_IDLE;
          cnt_s    = 6'd0;
          shadow_s = '0;
          abort_s  = 1'b1;
        end else begin
          state_s = ST_COLLECT;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        cnt_s    = 6'd0;
        shadow_s = '0;
      end
    endcase
  end

  // Frame state, shadow and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 6'd0;
      shadow_r <= '0;
      packet_r <= '0;
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      shadow_r <= shadow_s;
      packet_r <= packet_s;
      ready_r  <= ready_s;
    end
  end

  assign packet = packet_r;
  assign ready  = ready_r;
  assign busy   = (state_r == ST_COLLECT);

endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: table vectors, directed frame sequences and random
// traffic checked against a queue-based frame model.
module tb_packet_assembler;

  localparam logic [7:0] SYNC = 8'h7E;
  localparam int         TCYC = 8;
`ifdef PKT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic [287:0] packet;
  logic         ready;
  logic         busy;
  logic [7:0]   drop_count;

  int n_pass   = 0;
  int n_checks = 0;
  int n_ready  = 0;

  // model state
  bit           m_in;
  logic [7:0]   m_q[$];
  int           m_idle;
  logic [287:0] m_pkt;
  bit           m_ready;
  int           m_drop;

  typedef struct {
    bit         v;
    logic [7:0] b;
    bit         busy;
  } vec_t;
  vec_t tbl[6];

  packet_assembler #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TCYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .packet     (packet),
    .ready      (ready),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string name, logic [287:0] act, logic [287:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endfunction

  task automatic model_reset();
    m_in = 0; m_q.delete(); m_idle = 0; m_pkt = '0; m_ready = 0; m_drop = 0;
  endtask

  // Frame rules: sync starts a frame, 36 data bytes complete it, TCYC idle
  // cycles inside a frame abort it (watchdog builds only).
  task automatic model_step(input bit v, input logic [7:0] b);
    m_ready = 0;
    if (!m_in) begin
      if (v && b == SYNC) begin
        m_in = 1; m_q.delete(); m_idle = 0;
      end
    end else if (v) begin
      m_q.push_back(b);
      m_idle = 0;
      if (m_q.size() == 36) begin
        for (int i = 0; i < 36; i++) m_pkt[287-8*i -: 8] = m_q[i];
        m_ready = 1;
        m_in = 0;
      end
    end else begin
      m_idle++;
      if (TO_EN && m_idle >= TCYC) begin
        m_in = 0;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] b);
    byte_in    = b;
    byte_valid = v;
    model_step(v, b);
    @(posedge clk);
    #1;
    check("ready", 288'(ready), 288'(m_ready));
    check("busy", 288'(busy), 288'(m_in));
    check("packet", packet, m_pkt);
    check("drop", 288'(drop_count), 288'(m_drop));
    if (ready) n_ready++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    byte_valid = 1'b0;
    model_reset();
    #1;
    check("rst_packet", packet, 288'd0);
    check("rst_busy", 288'(busy), 288'd0);
    @(posedge clk);
    #1;
    check("rst_ready", 288'(ready), 288'd0);
    check("rst_drop", 288'(drop_count), 288'd0);
    check("rst_packet2", packet, 288'd0);
    reset = 1'b1;
  endtask

  initial begin
    logic [287:0] saved;
    reset = 1'b0; byte_in = 8'd0; byte_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // IDLE rejection, sync detection, sync value as data
    tbl[0] = '{1'b1, 8'h55, 1'b0};
    tbl[1] = '{1'b1, 8'hAA, 1'b0};
    tbl[2] = '{1'b0, 8'h7E, 1'b0};
    tbl[3] = '{1'b1, 8'h7E, 1'b1};
    tbl[4] = '{1'b1, 8'h7E, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].b);
      check($sformatf("tbl%0d_busy", i), 288'(busy), 288'(tbl[i].busy));
    end
    for (int k = 1; k < 36; k++) cycle(1'b1, 8'(k));
    check("tbl_ready", 288'(ready), 288'd1);
    check("tbl_first", 288'(packet[287:280]), 288'h7E);
    check("tbl_second", 288'(packet[279:272]), 288'h01);
    check("tbl_last", 288'(packet[7:0]), 288'h23);

    // basic frame 00..23
    n_ready = 0;
    cycle(1'b1, SYNC);
    for (int i = 0; i < 36; i++) cycle(1'b1, 8'(i));
    check("basic_ready", 288'(ready), 288'd1);
    check("basic_first", 288'(packet[287:280]), 288'h00);
    check("basic_last", 288'(packet[7:0]), 288'h23);
    cycle(1'b0, 8'h00);
    check("basic_ready_drop", 288'(ready), 288'd0);
    check("basic_ready_count", 288'(n_ready), 288'd1);

    // sync value as data byte 10, no resync
    cycle(1'b1, SYNC);
    for (int i = 0; i < 36; i++) cycle(1'b1, (i == 10) ? SYNC : 8'(i + 8'h40));
    check("sync_data", 288'(packet[207:200]), 288'h7E);
    check("sync_data_last", 288'(packet[7:0]), 288'h63);
    check("sync_data_ready", 288'(ready), 288'd1);

    // back-to-back: next sync in the ready cycle
    n_ready = 0;
    cycle(1'b1, SYNC);
    for (int i = 0; i < 36; i++) cycle(1'b1, 8'(i) ^ 8'hA5);
    cycle(1'b1, SYNC);
    for (int i = 0; i < 36; i++) cycle(1'b1, 8'(i) ^ 8'h3C);
    cycle(1'b0, 8'h00);
    check("b2b_ready_count", 288'(n_ready), 288'd2);
    check("b2b_first", 288'(packet[287:280]), 288'h3C);

    // reset mid-frame, then a clean frame
    cycle(1'b1, SYNC);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i + 8'h10));
    do_reset();
    n_ready = 0;
    cycle(1'b1, SYNC);
    for (int i = 0; i < 36; i++) cycle(1'b1, 8'(i + 8'h80));
    cycle(1'b0, 8'h00);
    check("rst_frame_ready_count", 288'(n_ready), 288'd1);
    check("rst_frame_drop", 288'(drop_count), 288'd0);
    check("rst_frame_first", 288'(packet[287:280]), 288'h80);

`ifdef PKT_TIMEOUT_EN
    // single timeout abort
    n_ready = 0;
    saved = m_pkt;
    cycle(1'b1, SYNC);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 8'hC0));
    for (int i = 0; i < TCYC; i++) cycle(1'b0, 8'h00);
    check("to_busy", 288'(busy), 288'd0);
    check("to_drop", 288'(drop_count), 288'd1);
    check("to_packet", packet, saved);
    check("to_no_ready", 288'(n_ready), 288'd0);

    // byte on the expiry cycle is accepted
    cycle(1'b1, SYNC);
    cycle(1'b1, 8'h11);
    for (int i = 0; i < TCYC - 1; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h22);
    check("to_race_busy", 288'(busy), 288'd1);
    check("to_race_drop", 288'(drop_count), 288'd1);
    for (int i = 0; i < TCYC - 1; i++) cycle(1'b0, 8'h00);
    check("to_race_busy2", 288'(busy), 288'd1);
    cycle(1'b0, 8'h00);
    check("to_race_abort", 288'(busy), 288'd0);
    check("to_race_drop2", 288'(drop_count), 288'd2);

    // saturation
    for (int n = 0; n < 256; n++) begin
      cycle(1'b1, SYNC);
      cycle(1'b1, 8'h01);
      for (int i = 0; i < TCYC; i++) cycle(1'b0, 8'h00);
    end
    check("to_sat", 288'(drop_count), 288'd255);
    check("to_sat_packet", packet, saved);
`endif

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
      end else begin
        cycle($urandom_range(0, 3) != 0,
              ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
